// File: rtl/simon_seq_engine.sv
// Simon Says round sequencer: grows a random colour sequence, plays it back on
// four LEDs, then checks the player's presses against it within a timeout.
module simon_seq_engine #(
    parameter int MAX_LEN       = 16,
    parameter int ON_TICKS      = 4,
    parameter int OFF_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 32,
    localparam int LW           = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [7:0]    rand_in,
    input  logic          start,
    input  logic          tick,
    input  logic [3:0]    btn,
    output logic [3:0]    led,
    output logic          await_input,
    output logic          busy,
    output logic [LW-1:0] level,
    output logic          win,
    output logic          lose
);
    localparam int AW = $clog2(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_ADD, S_SHOW_ON, S_SHOW_OFF, S_WAIT_IN, S_WIN, S_LOSE
    } state_t;

    state_t        r_state;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_idx;
    logic [7:0]    r_cnt;
    logic [1:0]    r_mem [MAX_LEN];
    logic [3:0]    r_led;
    logic          r_await;
    logic          r_busy;
    logic          r_win;
    logic          r_lose;

    state_t        w_state;
    logic [LW-1:0] w_len;
    logic [LW-1:0] w_idx;
    logic [7:0]    w_cnt;
    logic          w_we;
    logic          w_last;
    logic [3:0]    w_exp;
    logic [1:0]    w_color;
    logic          w_unused_rand;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    assign w_unused_rand = ^rand_in[7:2];
    assign w_last        = (r_idx == r_len - LW'(1));
    assign w_exp         = onehot(r_mem[r_idx[AW-1:0]]);
    // The first colour of a new game is written in the same cycle it is first shown.
    assign w_color       = (r_state == S_ADD && r_len == '0) ? rand_in[1:0]
                                                             : r_mem[w_idx[AW-1:0]];

    always_comb begin
        w_state = r_state;
        w_len   = r_len;
        w_idx   = r_idx;
        w_cnt   = r_cnt;
        w_we    = 1'b0;
        case (r_state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    w_len   = '0;
                    w_idx   = '0;
                    w_state = S_ADD;
                end
            end
            S_ADD: begin
                w_we    = 1'b1;
                w_len   = r_len + LW'(1);
                w_idx   = '0;
                w_cnt   = '0;
                w_state = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                if (tick) begin
                    if (r_cnt == 8'(ON_TICKS - 1)) begin
                        w_cnt   = '0;
                        w_state = S_SHOW_OFF;
                    end else begin
                        w_cnt = r_cnt + 8'd1;
                    end
                end
            end
            S_SHOW_OFF: begin
                if (tick) begin
                    if (r_cnt == 8'(OFF_TICKS - 1)) begin
                        w_cnt = '0;
                        if (w_last) begin
                            w_idx   = '0;
                            w_state = S_WAIT_IN;
                        end else begin
                            w_idx   = r_idx + LW'(1);
                            w_state = S_SHOW_ON;
                        end
                    end else begin
                        w_cnt = r_cnt + 8'd1;
                    end
                end
            end
            S_WAIT_IN: begin
                // A press takes priority over a simultaneous tick.
                if (btn != 4'b0000) begin
                    w_cnt = '0;
                    if (btn != w_exp) begin
                        w_state = S_LOSE;
                    end else if (!w_last) begin
                        w_idx = r_idx + LW'(1);
                    end else if (r_len == LW'(MAX_LEN)) begin
                        w_state = S_WIN;
                    end else begin
                        w_state = S_ADD;
                    end
                end else if (tick) begin
                    if (r_cnt == 8'(TIMEOUT_TICKS - 1)) begin
                        w_state = S_LOSE;
                    end else begin
                        w_cnt = r_cnt + 8'd1;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_led   <= '0;
            r_await <= 1'b0;
            r_busy  <= 1'b0;
            r_win   <= 1'b0;
            r_lose  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_len   <= w_len;
            r_idx   <= w_idx;
            r_cnt   <= w_cnt;
            r_led   <= (w_state == S_SHOW_ON) ? onehot(w_color) : 4'b0000;
            r_await <= (w_state == S_WAIT_IN);
            r_busy  <= (w_state == S_ADD) || (w_state == S_SHOW_ON) ||
                       (w_state == S_SHOW_OFF) || (w_state == S_WAIT_IN);
            r_win   <= (w_state == S_WIN);
            r_lose  <= (w_state == S_LOSE);
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_len[AW-1:0]] <= rand_in[1:0];
        end
    end

    assign led         = r_led;
    assign await_input = r_await;
    assign busy        = r_busy;
    assign level       = r_len;
    assign win         = r_win;
    assign lose        = r_lose;
endmodule
